pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 24 ++
 rtl/pc_redirect_ctrl_sat_counter.sv | 39 +++
 rtl/pc_redirect_ctrl.sv | 141 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// ============================================================================
// Module : pc_redirect_ctrl_pkg
// Brief  : Shared front-end constants: reset PC, FSM and redirect-kind codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pc_redirect_ctrl_pkg;

    localparam logic [31:0] C_PC_INIT_ADDR = 32'h0000_3000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } redir_state_e;

    typedef enum logic [0:0] {
        KIND_JUMP   = 1'b0,
        KIND_BRANCH = 1'b1
    } redir_kind_e;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter with increment enable that saturates at all-ones.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Inc_i,
    output logic [WIDTH-1:0] Count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module : pc_redirect_ctrl
// Brief  : Next-PC selection with branch/jump redirects held across freezes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] INIT_ADDR = C_PC_INIT_ADDR,
    parameter int          CNT_W     = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic             Stall,
    input  logic             Freeze,
    input  logic             Beq_Taken,
    input  logic [31:0]      Branch_PC,
    input  logic             Jump,
    input  logic [25:0]      Jump_immed,
    input  logic [31:0]      ID_PC,
    output logic [31:0]      PC_Next,
    output logic             PC_Write,
    output logic             Flush_IF_ID,
    output logic             Flush_ID_EX,
    output logic             Redirect_Pending,
    output logic [CNT_W-1:0] Redirect_Count,
    output logic [CNT_W-1:0] Stall_Count
);

    redir_state_e state_q, state_d;
    redir_kind_e  kind_q,  kind_d;
    logic [31:0]  tgt_q,   tgt_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  jump_tgt;
    logic         redirect;

    assign pc_plus4 = PC + 32'd4;
    // Region bits come from the ID-stage PC, the rest from the index field.
    assign jump_tgt = (ID_PC & 32'hF000_0000) | {4'b0000, Jump_immed, 2'b00};

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        tgt_d       = tgt_q;
        PC_Next     = pc_plus4;
        PC_Write    = 1'b1;
        Flush_IF_ID = 1'b0;
        Flush_ID_EX = 1'b0;
        redirect    = 1'b0;

        if (Reset) begin
            PC_Next  = INIT_ADDR;
            PC_Write = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (Freeze) begin
                        PC_Write = 1'b0;
                        if (Beq_Taken) begin
                            tgt_d   = Branch_PC;
                            kind_d  = KIND_BRANCH;
                            state_d = ST_PEND;
                        end else if (Jump && !Stall) begin
                            tgt_d   = jump_tgt;
                            kind_d  = KIND_JUMP;
                            state_d = ST_PEND;
                        end
                    end else if (Beq_Taken) begin
                        PC_Next     = Branch_PC;
                        Flush_IF_ID = 1'b1;
                        Flush_ID_EX = 1'b1;
                        redirect    = 1'b1;
                    end else if (Stall) begin
                        PC_Write    = 1'b0;
                        Flush_ID_EX = 1'b1;
                    end else if (Jump) begin
                        PC_Next     = jump_tgt;
                        Flush_IF_ID = 1'b1;
                        redirect    = 1'b1;
                    end
                end
                ST_PEND: begin
                    if (Freeze) begin
                        PC_Write = 1'b0;
                        // An older branch outranks the younger pending jump.
                        if (Beq_Taken && (kind_q == KIND_JUMP)) begin
                            tgt_d  = Branch_PC;
                            kind_d = KIND_BRANCH;
                        end
                    end else begin
                        PC_Next     = tgt_q;
                        Flush_IF_ID = 1'b1;
                        Flush_ID_EX = (kind_q == KIND_BRANCH);
                        redirect    = 1'b1;
                        tgt_d       = '0;
                        kind_d      = KIND_JUMP;
                        state_d     = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            kind_q  <= KIND_JUMP;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            tgt_q   <= tgt_d;
        end
    end

    assign Redirect_Pending = (state_q == ST_PEND) && !Reset;

    sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .Clock   (Clock),
        .Reset   (Reset),
        .Inc_i   (redirect),
        .Count_o (Redirect_Count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .Clock   (Clock),
        .Reset   (Reset),
        .Inc_i   (!PC_Write && !Reset),
        .Count_o (Stall_Count)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ============================================================================
// Module : tb_pc_redirect_ctrl
// Brief  : Directed plus randomized checks of pc_redirect_ctrl against a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_redirect_ctrl;

    localparam int          C_CNT_W = 16;
    localparam int          C_SAT   = (1 << C_CNT_W) - 1;
    localparam logic [31:0] C_INIT  = 32'h0000_3000;

    logic               Clock = 1'b0;
    logic               Reset;
    logic [31:0]        PC;
    logic               Stall;
    logic               Freeze;
    logic               Beq_Taken;
    logic [31:0]        Branch_PC;
    logic               Jump;
    logic [25:0]        Jump_immed;
    logic [31:0]        ID_PC;
    logic [31:0]        PC_Next;
    logic               PC_Write;
    logic               Flush_IF_ID;
    logic               Flush_ID_EX;
    logic               Redirect_Pending;
    logic [C_CNT_W-1:0] Redirect_Count;
    logic [C_CNT_W-1:0] Stall_Count;

    int checks   = 0;
    int failures = 0;

    // Reference state: what is waiting to be applied and the two statistics.
    bit          m_pend;
    bit          m_is_br;
    logic [31:0] m_tgt;
    int          m_rcnt;
    int          m_scnt;

    always #5 Clock = ~Clock;

    pc_redirect_ctrl #(.INIT_ADDR(C_INIT), .CNT_W(C_CNT_W)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .PC               (PC),
        .Stall            (Stall),
        .Freeze           (Freeze),
        .Beq_Taken        (Beq_Taken),
        .Branch_PC        (Branch_PC),
        .Jump             (Jump),
        .Jump_immed       (Jump_immed),
        .ID_PC            (ID_PC),
        .PC_Next          (PC_Next),
        .PC_Write         (PC_Write),
        .Flush_IF_ID      (Flush_IF_ID),
        .Flush_ID_EX      (Flush_ID_EX),
        .Redirect_Pending (Redirect_Pending),
        .Redirect_Count   (Redirect_Count),
        .Stall_Count      (Stall_Count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        Stall = 0; Freeze = 0; Beq_Taken = 0; Jump = 0;
        Branch_PC = 32'h0; Jump_immed = 26'h0; ID_PC = 32'h0;
    endtask

    // Called after inputs are set between edges: predicts and checks this
    // cycle's outputs, then advances the reference to the coming rising edge.
    task automatic step();
        logic [31:0] e_next;
        bit          e_wr, e_fi, e_fe, e_redir;
        #1;
        e_next  = PC + 32'd4;
        e_wr    = 1; e_fi = 0; e_fe = 0; e_redir = 0;
        if (Reset) begin
            e_next = C_INIT; e_wr = 0;
            m_pend = 0; m_is_br = 0; m_tgt = '0; m_rcnt = 0; m_scnt = 0;
        end else if (m_pend && !Freeze) begin
            e_next = m_tgt; e_fi = 1; e_fe = m_is_br; e_redir = 1;
        end else if (Freeze) begin
            e_wr = 0;
        end else if (Beq_Taken) begin
            e_next = Branch_PC; e_fi = 1; e_fe = 1; e_redir = 1;
        end else if (Stall) begin
            e_wr = 0; e_fe = 1;
        end else if (Jump) begin
            e_next = {ID_PC[31:28], Jump_immed, 2'b00}; e_fi = 1; e_redir = 1;
        end

        chk("pc_write", 32'(PC_Write), 32'(e_wr));
        chk("flush_if_id", 32'(Flush_IF_ID), 32'(e_fi));
        chk("flush_id_ex", 32'(Flush_ID_EX), 32'(e_fe));
        chk("pending", 32'(Redirect_Pending), 32'(m_pend && !Reset));
        chk("redirect_cnt", 32'(Redirect_Count), 32'(m_rcnt));
        chk("stall_cnt", 32'(Stall_Count), 32'(m_scnt));
        if (e_wr || Reset) chk("pc_next", PC_Next, e_next);

        if (!Reset) begin
            if (e_redir && m_rcnt < C_SAT) m_rcnt++;
            if (!e_wr && m_scnt < C_SAT) m_scnt++;
            if (m_pend) begin
                if (!Freeze) begin
                    m_pend = 0; m_is_br = 0; m_tgt = '0;
                end else if (Beq_Taken && !m_is_br) begin
                    m_tgt = Branch_PC; m_is_br = 1;
                end
            end else if (Freeze) begin
                if (Beq_Taken) begin
                    m_pend = 1; m_is_br = 1; m_tgt = Branch_PC;
                end else if (Jump && !Stall) begin
                    m_pend = 1; m_is_br = 0; m_tgt = {ID_PC[31:28], Jump_immed, 2'b00};
                end
            end
        end
    endtask

    initial begin
        int r0, s0;
        idle_inputs();
        PC    = 32'h3000;
        Reset = 1;
        @(negedge Clock);
        step();
        chk("reset_pc_next", PC_Next, 32'h0000_3000);
        @(negedge Clock);
        Reset = 0;

        // Sequential fetch.
        step();
        chk("seq_pc_next", PC_Next, 32'h0000_3004);

        // Branch beats stall and jump.
        @(negedge Clock);
        Beq_Taken = 1; Branch_PC = 32'h3040; Stall = 1; Jump = 1;
        step();
        chk("beq_pc_next", PC_Next, 32'h0000_3040);
        @(negedge Clock);
        idle_inputs();
        step();
        chk("beq_cnt", 32'(Redirect_Count), 32'd1);

        // Jump target assembly.
        @(negedge Clock);
        Jump = 1; ID_PC = 32'h3008; Jump_immed = 26'h0000C10;
        step();
        chk("jump_pc_next", PC_Next, 32'h0000_3040);
        chk("jump_fe", 32'(Flush_ID_EX), 32'd0);

        // Frozen jump, then branch overwrite, then release.
        s0 = m_scnt;
        @(negedge Clock);
        idle_inputs(); Freeze = 1; Jump = 1; ID_PC = 32'h3008; Jump_immed = 26'h0000C10;
        step();
        @(negedge Clock);
        Beq_Taken = 1; Branch_PC = 32'h3100;
        step();
        @(negedge Clock);
        Beq_Taken = 0;
        step();
        @(negedge Clock);
        idle_inputs();
        step();
        chk("frz_pc_next", PC_Next, 32'h0000_3100);
        chk("frz_fe", 32'(Flush_ID_EX), 32'd1);
        chk("frz_stall_cnt", 32'(Stall_Count), 32'(s0 + 3));
        @(negedge Clock);
        step();
        chk("frz_released", 32'(Redirect_Pending), 32'd0);

        // Reset while a redirect is pending discards it.
        @(negedge Clock);
        Freeze = 1; Beq_Taken = 1; Branch_PC = 32'h3200;
        step();
        @(negedge Clock);
        idle_inputs(); Freeze = 1;
        step();
        chk("pend_set", 32'(Redirect_Pending), 32'd1);
        @(negedge Clock);
        Reset = 1;
        step();
        chk("rst_pend_clr", 32'(Redirect_Pending), 32'd0);
        chk("rst_pc_next", PC_Next, 32'h0000_3000);
        @(negedge Clock);
        Reset = 0; idle_inputs(); PC = 32'hFFFF_FFFC;
        step();
        chk("wrap_pc_next", PC_Next, 32'h0000_0000);
        r0 = m_rcnt;
        chk("discard_cnt", 32'(Redirect_Count), 32'(r0));

        // Stall counter saturation.
        PC = 32'h3000;
        for (int i = 0; i < (1 << C_CNT_W) + 5; i++) begin
            @(negedge Clock);
            Stall = 1;
            step();
        end
        @(negedge Clock);
        Stall = 0;
        step();
        chk("stall_sat", 32'(Stall_Count), 32'(C_SAT));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clock);
            Reset      = ($urandom_range(0, 99) == 0);
            Freeze     = ($urandom_range(0, 99) < 30);
            Stall      = ($urandom_range(0, 99) < 20);
            Beq_Taken  = ($urandom_range(0, 99) < 20);
            Jump       = ($urandom_range(0, 99) < 30);
            PC         = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            Branch_PC  = $urandom() & 32'hFFFF_FFFC;
            ID_PC      = $urandom();
            Jump_immed = 26'($urandom());
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
